// File: rtl/accel_run_timer_pkg.sv
// Shared types for the accelerator run timer: FSM and converter state
// encodings, BCD digit width and a small state-decode helper.
package run_timer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_EXE   = 3'd2,
    S_CONV  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_RUN  = 2'd1,
    C_FIN  = 2'd2
  } cvt_t;

  localparam int BCD_W = 4;

  function automatic logic is_busy(state_t s);
    return (s == S_START) || (s == S_EXE) ||
           (s == S_CONV);
  endfunction

endpackage

// File: rtl/accel_run_timer_if.sv
// Accelerator handshake: start pulse out, finish flag and result back.
// master = run controller, slave = accelerator.
interface accel_run_timer_if #(
  parameter int RESULT_W = 32
);

  logic                start;
  logic                finish;
  logic [RESULT_W-1:0] return_val;

  modport master (
    output start,
    input  finish,
    input  return_val
  );

  modport slave (
    input  start,
    output finish,
    output return_val
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: load captures value, one bit per cycle,
// done pulses for one cycle with bcd digits and overflow flag valid.
module bin2bcd_seq
  import run_timer_pkg::*;
#(
  parameter int IN_W   = 32,
  parameter int DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [IN_W-1:0]         value,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic                    ovf
);

  localparam int BW = BCD_W * DIGITS;
  localparam int CW = $clog2(IN_W + 1);

  cvt_t          ph;
  cvt_t          ph_nx;
  logic [IN_W-1:0] sr;
  logic [BW-1:0]   acc;
  logic [BW-1:0]   adj;
  logic [CW-1:0]   left;
  logic            ov;

  always_comb begin
    adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[i*BCD_W +: BCD_W] > 4'd4)
        adj[i*BCD_W +: BCD_W] =
          acc[i*BCD_W +: BCD_W] + 4'd3;
    end
  end

  always_comb begin
    ph_nx = ph;
    unique case (ph)
      C_IDLE:  if (load) ph_nx = C_RUN;
      C_RUN:   if (left == CW'(1)) ph_nx = C_FIN;
      C_FIN:   ph_nx = C_IDLE;
      default: ph_nx = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ph <= C_IDLE;
    else          ph <= ph_nx;
  end

  // A corrected top digit carrying out a 1 means the value so far
  // already exceeds the digit range; prefixes only grow, so it sticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr   <= '0;
      acc  <= '0;
      left <= '0;
      ov   <= 1'b0;
    end else if (ph == C_IDLE && load) begin
      sr   <= value;
      acc  <= '0;
      left <= CW'(IN_W);
      ov   <= 1'b0;
    end else if (ph == C_RUN) begin
      sr   <= sr << 1;
      acc  <= {adj[BW-2:0], sr[IN_W-1]};
      ov   <= ov | adj[BW-1];
      left <= left - CW'(1);
    end
  end

  assign busy = (ph != C_IDLE);
  assign done = (ph == C_FIN);
  assign bcd  = acc;
  assign ovf  = ov;

endmodule

// File: rtl/accel_run_timer.sv
// Run controller and cycle timer: go edge -> N_RUNS accelerator runs,
// cycle count, result capture, optional timeout, BCD conversion.
module accel_run_timer
  import run_timer_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int RESULT_W    = 32,
  parameter int N_RUNS      = 1,
  parameter int TIMEOUT_CYC = 0,
  parameter int DIGITS      = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    go,
  input  logic                    disp_sel,
  accel_run_timer_if.master       acc,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout,
  output logic                    cnt_ovf,
  output logic                    bcd_ovf,
  output logic [CNT_W-1:0]        total_cycles,
  output logic [RESULT_W-1:0]     last_result,
  output logic [BCD_W*DIGITS-1:0] digits,
  output logic [2:0]              state
);

  localparam int DW    = BCD_W * DIGITS;
  localparam int RUN_W = (N_RUNS > 1) ? $clog2(N_RUNS) : 1;
  localparam logic [RUN_W-1:0] LAST_IDX =
    RUN_W'(N_RUNS - 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYC);
  localparam bit TMO_EN = (TIMEOUT_CYC != 0);
  localparam logic [DW-1:0] NINES = {DIGITS{4'h9}};

  state_t           st;
  state_t           st_nx;
  logic             go_q;
  logic             go_rise;
  logic [CNT_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_idx;
  logic             tmo_hit;

  logic clr_meas;
  logic clr_run;
  logic cnt_en;
  logic cap;
  logic idx_inc;
  logic set_to;
  logic wb;

  logic             cvt_load;
  logic             cvt_busy;
  logic             cvt_done;
  logic             cvt_ovf;
  logic [DW-1:0]    cvt_bcd;
  logic [CNT_W-1:0] result_fit;
  logic [CNT_W-1:0] cvt_in;

  assign go_rise = go & ~go_q;
  assign tmo_hit = TMO_EN && (run_cnt == TMO);

  always_comb begin
    st_nx    = st;
    clr_meas = 1'b0;
    clr_run  = 1'b0;
    cnt_en   = 1'b0;
    cap      = 1'b0;
    idx_inc  = 1'b0;
    set_to   = 1'b0;
    cvt_load = 1'b0;
    wb       = 1'b0;
    unique case (st)
      S_IDLE, S_DONE: begin
        if (go_rise) begin
          st_nx    = S_START;
          clr_meas = 1'b1;
          clr_run  = 1'b1;
        end
      end
      S_START: st_nx = S_EXE;
      S_EXE: begin
        if (acc.finish) begin
          cap = 1'b1;
          if (run_idx == LAST_IDX) begin
            st_nx = S_CONV;
          end else begin
            st_nx   = S_START;
            idx_inc = 1'b1;
            clr_run = 1'b1;
          end
        end else if (tmo_hit) begin
          st_nx  = S_CONV;
          set_to = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_CONV: begin
        cvt_load = ~cvt_busy;
        if (cvt_done) begin
          wb    = 1'b1;
          st_nx = S_DONE;
        end
      end
      default: st_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st   <= S_IDLE;
      go_q <= 1'b0;
    end else begin
      st   <= st_nx;
      go_q <= go;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    run_cnt <= '0;
    else if (clr_run) run_cnt <= '0;
    else if (cnt_en)  run_cnt <= run_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      total_cycles <= '0;
      run_idx      <= '0;
      timeout      <= 1'b0;
      cnt_ovf      <= 1'b0;
      bcd_ovf      <= 1'b0;
      digits       <= '0;
    end else if (clr_meas) begin
      total_cycles <= '0;
      run_idx      <= '0;
      timeout      <= 1'b0;
      cnt_ovf      <= 1'b0;
      bcd_ovf      <= 1'b0;
    end else begin
      if (cnt_en) begin
        if (&total_cycles) cnt_ovf <= 1'b1;
        else total_cycles <= total_cycles + CNT_W'(1);
      end
      if (idx_inc) run_idx <= run_idx + RUN_W'(1);
      if (set_to)  timeout <= 1'b1;
      if (wb) begin
        bcd_ovf <= cvt_ovf;
        digits  <= cvt_ovf ? NINES : cvt_bcd;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_result <= '0;
    else if (cap) last_result <= acc.return_val;
  end

  generate
    if (RESULT_W >= CNT_W) begin : g_trunc
      assign result_fit = last_result[CNT_W-1:0];
    end else begin : g_zext
      assign result_fit =
        {{(CNT_W-RESULT_W){1'b0}}, last_result};
    end
  endgenerate

  assign cvt_in = disp_sel ? result_fit : total_cycles;

  bin2bcd_seq #(
    .IN_W   (CNT_W),
    .DIGITS (DIGITS)
  ) u_bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (cvt_load),
    .value   (cvt_in),
    .busy    (cvt_busy),
    .done    (cvt_done),
    .bcd     (cvt_bcd),
    .ovf     (cvt_ovf)
  );

  assign acc.start = (st == S_START);
  assign busy      = is_busy(st);
  assign done      = (st == S_DONE);
  assign state     = st;

endmodule

// File: tb/tb_accel_run_timer.sv
// Bench for accel_run_timer: three parameterisations checked each
// cycle against a behavioural model, plus directed literal checks.
module tb_accel_run_timer;

  localparam int ND = 3;
  localparam int P_CW [ND] = '{32, 32, 8};
  localparam int P_RW [ND] = '{32, 32, 16};
  localparam int P_NR [ND] = '{1, 3, 1};
  localparam int P_TO [ND] = '{0, 100, 0};
  localparam int P_DG [ND] = '{6, 6, 2};

  typedef struct packed {
    logic [2:0]  st;
    logic        start;
    logic        busy;
    logic        done;
    logic        to;
    logic        covf;
    logic        bovf;
    logic [31:0] tot;
    logic [31:0] last;
    logic [23:0] dig;
  } obs_t;

  typedef struct {
    int          st;
    logic        go_q;
    logic [63:0] total;
    logic [63:0] runcnt;
    logic [63:0] last;
    logic [63:0] dig;
    logic [63:0] cval;
    int          runidx;
    int          cleft;
    bit          to;
    bit          covf;
    bit          bovf;
  } mdl_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #10 clk = ~clk;

  logic        go   [ND];
  logic        dsel [ND];
  logic        fin  [ND];
  logic [31:0] rv   [ND];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int starts [ND];
  mdl_t m [ND];

  accel_run_timer_if #(.RESULT_W(32)) if0 ();
  accel_run_timer_if #(.RESULT_W(32)) if1 ();
  accel_run_timer_if #(.RESULT_W(16)) if2 ();

  assign if0.finish     = fin[0];
  assign if0.return_val = rv[0];
  assign if1.finish     = fin[1];
  assign if1.return_val = rv[1];
  assign if2.finish     = fin[2];
  assign if2.return_val = rv[2][15:0];

  logic [2:0]  st0, st1, st2;
  logic        bz0, bz1, bz2, dn0, dn1, dn2;
  logic        to0, to1, to2, co0, co1, co2;
  logic        bo0, bo1, bo2;
  logic [31:0] tot0, tot1, last0, last1;
  logic [7:0]  tot2;
  logic [15:0] last2;
  logic [23:0] dig0, dig1;
  logic [7:0]  dig2;

  accel_run_timer #(
    .CNT_W(32), .RESULT_W(32), .N_RUNS(1),
    .TIMEOUT_CYC(0), .DIGITS(6)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .go(go[0]),
    .disp_sel(dsel[0]), .acc(if0), .busy(bz0),
    .done(dn0), .timeout(to0), .cnt_ovf(co0),
    .bcd_ovf(bo0), .total_cycles(tot0),
    .last_result(last0), .digits(dig0), .state(st0)
  );

  accel_run_timer #(
    .CNT_W(32), .RESULT_W(32), .N_RUNS(3),
    .TIMEOUT_CYC(100), .DIGITS(6)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .go(go[1]),
    .disp_sel(dsel[1]), .acc(if1), .busy(bz1),
    .done(dn1), .timeout(to1), .cnt_ovf(co1),
    .bcd_ovf(bo1), .total_cycles(tot1),
    .last_result(last1), .digits(dig1), .state(st1)
  );

  accel_run_timer #(
    .CNT_W(8), .RESULT_W(16), .N_RUNS(1),
    .TIMEOUT_CYC(0), .DIGITS(2)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .go(go[2]),
    .disp_sel(dsel[2]), .acc(if2), .busy(bz2),
    .done(dn2), .timeout(to2), .cnt_ovf(co2),
    .bcd_ovf(bo2), .total_cycles(tot2),
    .last_result(last2), .digits(dig2), .state(st2)
  );

  function automatic obs_t snap(int k);
    obs_t o;
    case (k)
      0: o = {st0, if0.start, bz0, dn0, to0, co0, bo0,
              tot0, last0, dig0};
      1: o = {st1, if1.start, bz1, dn1, to1, co1, bo1,
              tot1, last1, dig1};
      default: o = {st2, if2.start, bz2, dn2, to2, co2,
                    bo2, 24'd0, tot2, 16'd0, last2,
                    16'd0, dig2};
    endcase
    return o;
  endfunction

  function automatic logic [23:0] dec(logic [63:0] v,
                                      int nd,
                                      output bit ov);
    logic [63:0] lim = 64'd1;
    logic [23:0] d = '0;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    ov = (v >= lim);
    for (int i = 0; i < nd; i++) begin
      d[i*4 +: 4] = ov ? 4'h9 : 4'(v % 10);
      v = v / 10;
    end
    return d;
  endfunction

  function automatic mdl_t step(mdl_t c, int k);
    mdl_t n = c;
    logic [63:0] cmax = (64'd1 << P_CW[k]) - 1;
    logic [63:0] rmask = (64'd1 << P_RW[k]) - 1;
    logic rise = go[k] & ~c.go_q;
    bit ov;
    n.go_q = go[k];
    case (c.st)
      0, 4: if (rise) begin
        n.st = 1; n.total = 0; n.runidx = 0;
        n.to = 0; n.covf = 0; n.bovf = 0;
        n.runcnt = 0;
      end
      1: n.st = 2;
      2: begin
        if (fin[k]) begin
          n.last = {32'd0, rv[k]} & rmask;
          if (c.runidx + 1 < P_NR[k]) begin
            n.runidx = c.runidx + 1;
            n.runcnt = 0;
            n.st = 1;
          end else begin
            n.st = 3;
            n.cleft = P_CW[k] + 2;
          end
        end else if (P_TO[k] != 0 &&
                     c.runcnt == 64'(P_TO[k])) begin
          n.to = 1;
          n.st = 3;
          n.cleft = P_CW[k] + 2;
        end else begin
          n.runcnt = c.runcnt + 1;
          if (c.total == cmax) n.covf = 1;
          else n.total = c.total + 1;
        end
      end
      3: begin
        if (c.cleft == P_CW[k] + 2)
          n.cval = dsel[k] ? (c.last & cmax) : c.total;
        n.cleft = c.cleft - 1;
        if (n.cleft == 0) begin
          n.dig = {40'd0, dec(n.cval, P_DG[k], ov)};
          n.bovf = ov;
          n.st = 4;
        end
      end
      default: n.st = 0;
    endcase
    return n;
  endfunction

  function automatic obs_t expect_of(mdl_t c);
    obs_t o;
    o.st    = 3'(c.st);
    o.start = (c.st == 1);
    o.busy  = (c.st >= 1 && c.st <= 3);
    o.done  = (c.st == 4);
    o.to    = c.to;
    o.covf  = c.covf;
    o.bovf  = c.bovf;
    o.tot   = c.total[31:0];
    o.last  = c.last[31:0];
    o.dig   = c.dig[23:0];
    return o;
  endfunction

  initial begin
    obs_t a, e;
    for (int k = 0; k < ND; k++) begin
      m[k] = '{default: 0};
      starts[k] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int k = 0; k < ND; k++) begin
        if (!reset_n) m[k] = '{default: 0};
        else m[k] = step(m[k], k);
      end
      #1;
      for (int k = 0; k < ND; k++) begin
        a = snap(k);
        e = expect_of(m[k]);
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL model dut%0d cyc%0d got %h want %h",
                   k, cyc, a, e);
        end
        if (a.start) starts[k]++;
      end
    end
  end

  task automatic chk(string nm, logic [127:0] a,
                     logic [127:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic wait_state(int k, int s, int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (snap(k).st == 3'(s)) return;
    end
    chk($sformatf("wait_dut%0d_st%0d", k, s),
        128'(snap(k).st), 128'(s));
  endtask

  task automatic start_meas(int k, output int c);
    go[k] = 1'b0;
    @(negedge clk);
    go[k] = 1'b1;
    c = cyc;
  endtask

  task automatic drive_run(int k, int lat,
                           logic [31:0] val);
    wait_state(k, 2, 40);
    fin[k] = 1'b0;
    repeat (lat) @(negedge clk);
    fin[k] = 1'b1;
    rv[k] = val;
    @(negedge clk);
    fin[k] = 1'b0;
    rv[k] = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int n0;
    obs_t o;
    for (int k = 0; k < ND; k++) begin
      go[k] = 0; dsel[k] = 0; fin[k] = 0; rv[k] = 0;
    end
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < ND; k++)
      chk($sformatf("reset_dut%0d", k),
          128'(snap(k)), 128'(0));
    reset_n = 1'b1;

    @(negedge clk);
    fin[0] = 1'b1;
    rv[0] = 32'd99;
    repeat (2) @(negedge clk);
    fin[0] = 1'b0;
    chk("idle_finish_state", 128'(st0), 128'(0));
    chk("idle_finish_last", 128'(last0), 128'(0));

    start_meas(0, c);
    drive_run(0, 7, 32'h2A);
    wait_state(0, 4, 60);
    chk("t1_done_latency", 128'(cyc - c), 128'(44));
    o = snap(0);
    chk("t1_total", 128'(o.tot), 128'(7));
    chk("t1_last", 128'(o.last), 128'h2A);
    chk("t1_digits", 128'(o.dig), 128'h000007);
    chk("t1_done", 128'(o.done), 128'(1));
    go[0] = 1'b0;

    n0 = starts[0];
    start_meas(0, c);
    drive_run(0, 3, 32'd5);
    repeat (46) @(negedge clk);
    chk("held_go_starts", 128'(starts[0] - n0), 128'(1));
    chk("held_go_total", 128'(tot0), 128'(3));
    chk("held_go_done", 128'(dn0), 128'(1));
    go[0] = 1'b0;

    start_meas(0, c);
    wait_state(0, 2, 10);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    go[0] = 1'b0;
    #1;
    chk("midexe_reset", 128'(snap(0)), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    start_meas(0, c);
    drive_run(0, 9, 32'h77);
    wait_state(0, 4, 60);
    chk("fresh_total", 128'(tot0), 128'(9));
    chk("fresh_last", 128'(last0), 128'h77);
    chk("fresh_digits", 128'(dig0), 128'h000009);

    n0 = starts[1];
    start_meas(1, c);
    drive_run(1, 5, 32'd1);
    go[1] = 1'b0;
    drive_run(1, 10, 32'd2);
    go[1] = 1'b1;
    drive_run(1, 20, 32'd3);
    wait_state(1, 4, 60);
    chk("multi_starts", 128'(starts[1] - n0), 128'(3));
    chk("multi_total", 128'(tot1), 128'(35));
    chk("multi_last", 128'(last1), 128'(3));
    chk("multi_digits", 128'(dig1), 128'h000035);

    n0 = starts[1];
    start_meas(1, c);
    wait_state(1, 4, 200);
    chk("tmo_flag", 128'(to1), 128'(1));
    chk("tmo_total", 128'(tot1), 128'(100));
    chk("tmo_digits", 128'(dig1), 128'h000100);
    chk("tmo_starts", 128'(starts[1] - n0), 128'(1));

    start_meas(2, c);
    drive_run(2, 150, 32'h1234);
    wait_state(2, 4, 30);
    chk("ovf_digits", 128'(dig2), 128'h99);
    chk("ovf_flag", 128'(bo2), 128'(1));
    dsel[2] = 1'b1;
    repeat (2) @(negedge clk);
    chk("done_dsel_ignored", 128'(dig2), 128'h99);
    dsel[2] = 1'b0;
    start_meas(2, c);
    drive_run(2, 42, 32'h0BCD);
    wait_state(2, 4, 30);
    chk("rerun_digits", 128'(dig2), 128'h42);
    chk("rerun_ovf", 128'(bo2), 128'(0));

    dsel[2] = 1'b1;
    start_meas(2, c);
    drive_run(2, 2, 32'h1234);
    wait_state(2, 4, 30);
    chk("result_digits", 128'(dig2), 128'h52);
    chk("result_last", 128'(last2), 128'h1234);

    dsel[2] = 1'b0;
    start_meas(2, c);
    drive_run(2, 300, 32'd1);
    wait_state(2, 4, 30);
    chk("sat_total", 128'(tot2), 128'(255));
    chk("sat_flag", 128'(co2), 128'(1));
    chk("sat_digits", 128'(dig2), 128'h99);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/accel_run_timer.md
# accel_run_timer

Parametrised run controller and cycle timer for a LeFlow-generated accelerator (`top`) on the DE1-SoC. It sits between the board wrapper and the accelerator:
- detects a `go` edge and issues a single-cycle `start`;
- repeats the run `N_RUNS` times back to back, counting accelerator cycles and capturing the return value;
- supports an optional timeout;
- converts the measured count to BCD digits for the HEX displays with a sequential converter.

## Interface
Parameters:
- `CNT_W`, 32, width of the cycle counters.
- `RESULT_W`, 32, width of the accelerator return value.
- `N_RUNS`, 1, back-to-back runs per `go` (≥1).
- `TIMEOUT_CYC`, 0, per-run cycle limit; 0 disables the timeout.
- `DIGITS`, 6, number of BCD digits produced.

Ports:
- `clk` in 1: single clock, 50 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `go` in 1: synchronous level input; a rising edge requests a measurement.
- `disp_sel` in 1: selects the value converted to BCD; 0 = total cycles, 1 = last result.
- `finish` in 1: accelerator done flag.
- `return_val` in `RESULT_W`: accelerator result, valid while `finish`=1.
- `start` out 1: one-cycle start pulse to the accelerator.
- `busy` out 1: high in START, EXE and CONV.
- `done` out 1: high in DONE.
- `timeout` out 1: the last measurement aborted on `TIMEOUT_CYC`.
- `cnt_ovf` out 1: the total counter saturated.
- `bcd_ovf` out 1: the converted value exceeds 10^`DIGITS`−1.
- `total_cycles` out `CNT_W`: sum of EXE cycles over all runs.
- `last_result` out `RESULT_W`: `return_val` captured at the last finish.
- `digits` out 4·`DIGITS`: BCD digits; digit 0 is in bits [3:0].
- `state` out 3: current state encoding, for LEDs.

All outputs are 0 under reset, and the state is IDLE.

## Operation
- The FSM has five states: IDLE, START, EXE, CONV, DONE.
- IDLE → START on a `go` rising edge. The edge detector uses a registered `go`, which resets to 0.
- START entered from IDLE or DONE: clear `total_cycles`, `run_idx`, `timeout`, `cnt_ovf` and `bcd_ovf`.
- START entered from EXE (next run): clear nothing except `run_cnt`.
- START always asserts `start` and moves to EXE on the next cycle. `run_cnt` is cleared on every START entry.
- EXE with `finish`=0:
  - `run_cnt`+1 and `total_cycles`+1 each cycle.
  - `total_cycles` saturates at all-ones and sets `cnt_ovf`.
- EXE with `finish`=1:
  - Latch `return_val` into `last_result`.
  - If `run_idx`+1 < `N_RUNS`: increment `run_idx` and go to START.
  - Otherwise go to CONV.
- EXE timeout: when `TIMEOUT_CYC`≠0 and `run_cnt` reaches `TIMEOUT_CYC` with `finish`=0, set `timeout` and go to CONV. No further runs are started.
- CONV:
  - The converter loads the value chosen by `disp_sel`, zero-extended or truncated to `CNT_W`.
  - It runs `CNT_W` shift-add-3 iterations.
  - On converter done, update `digits` and `bcd_ovf`, then go to DONE.
  - If `bcd_ovf`, `digits` shows all nines.
- DONE holds all outputs. A `go` rising edge starts a new measurement (→START). `disp_sel` changes in DONE are ignored until the next measurement.
- `finish` is ignored in IDLE, START, CONV and DONE.
- `go` edges outside IDLE/DONE are ignored. `go` held high causes exactly one measurement.
- `reset_n` low at any time, including mid-EXE or mid-CONV, returns the block to IDLE with all registers cleared.

## Timing
- `go` rises sampled at cycle t → START at t+1 (`start`=1) → EXE at t+2.
- `total_cycles` equals the number of EXE cycles with `finish`=0. A `finish` in the first EXE cycle gives a count of 0.
- Each additional run costs one START cycle, which is not counted.
- CONV latency is `CNT_W`+2 cycles: load, `CNT_W` iterations, writeback. `done` rises the cycle after writeback.
- `last_result` updates on the clock edge that samples `finish`=1 in EXE.

## Structure
- Shared package `run_timer_pkg` holds:
  - state encoding constants (IDLE=0, START=1, EXE=2, CONV=3, DONE=4);
  - the BCD digit width constant (4).
- Sub-module `bin2bcd_seq` (params `IN_W`, `DIGITS`):
  - load/done handshake;
  - double-dabble, one bit per cycle;
  - outputs BCD digits plus an overflow flag.
- Top level holds the FSM, counters, edge detector and capture registers.

## Test plan
- `N_RUNS`=1, `finish` after 7 EXE cycles with `return_val`=0x2A → `total_cycles`=7, `last_result`=0x2A, `digits`=000007, `done`=1 at cycle t+2+8+`CNT_W`+2.
- `N_RUNS`=3, run latencies of 5, 10 and 20 cycles, return values 1, 2, 3 → three `start` pulses, `total_cycles`=35, `last_result`=3.
- `TIMEOUT_CYC`=100, `finish` never asserted → `timeout`=1 after 100 EXE cycles, `total_cycles`=100, `done`=1.
- `DIGITS`=2, run of 150 cycles → `digits`=99, `bcd_ovf`=1. Rerun with a 42-cycle run → `digits`=42, `bcd_ovf`=0.
- `reset_n` pulsed low mid-EXE → IDLE immediately, all outputs 0. A subsequent `go` gives a correct fresh count.
- `go` held high for 50 cycles across the whole run → exactly one `start` pulse. `finish` pulsed in IDLE → no state change.
